// File: rtl/instr_mem_ctrl.sv
// Instruction memory: self-clearing word array with a ready/valid loader port,
// a registered fetch/decode port and a registered byte-read port. Optional parity storage under INSTR_PARITY_EN.
module instr_mem_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 256,
    parameter int FIELD_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               prog_valid,
    output logic               prog_ready,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [DATA_W-1:0]  prog_data,
    input  logic               fetch_req,
    output logic               fetch_ready,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_valid,
    output logic [DATA_W-1:0]  instruction,
    output logic [FIELD_W-1:0] op,
    output logic [FIELD_W-1:0] rd,
    output logic [FIELD_W-1:0] rs,
    output logic [FIELD_W-1:0] rt,
    input  logic [ADDR_W-1:0]  byte_addr,
    output logic [DATA_W-1:0]  byte_data,
    output logic               busy,
`ifdef INSTR_PARITY_EN
    output logic               parity_err,
`endif
    output logic               addr_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW = DATA_W / 2;
`ifdef INSTR_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t             r_state;
    logic [IW-1:0]      r_cnt;
    logic [MW-1:0]      r_mem [DEPTH];
    logic               r_fetch_valid;
    logic [DATA_W-1:0]  r_instr;
    logic [DATA_W-1:0]  r_byte;
    logic               r_addr_err;

    logic [ADDR_W-1:0]  w_fidx;
    logic [ADDR_W-1:0]  w_bidx;
    logic               w_f_oor;
    logic               w_b_oor;
    logic               w_p_oor;
    logic               w_run;
    logic               w_fetch_go;
    logic               w_prog_go;
    logic               w_wr_en;
    logic [IW-1:0]      w_wr_idx;
    logic [DATA_W-1:0]  w_wr_data;
    logic [MW-1:0]      w_wr_word;
    logic [MW-1:0]      w_fword;
    logic [MW-1:0]      w_bword;
    logic [HW-1:0]      w_byte_sel;
    logic               w_unused;

    // Fetch addresses are byte addresses; bit 0 never selects anything.
    assign w_fidx   = {1'b0, fetch_addr[ADDR_W-1:1]};
    assign w_bidx   = {1'b0, byte_addr[ADDR_W-1:1]};
    assign w_unused = fetch_addr[0];

    assign w_f_oor  = ({1'b0, w_fidx}    >= LP_DEPTH);
    assign w_b_oor  = ({1'b0, w_bidx}    >= LP_DEPTH);
    assign w_p_oor  = ({1'b0, prog_addr} >= LP_DEPTH);

    assign w_run       = (r_state == S_RUN);
    assign busy        = (r_state == S_CLEAR);
    assign prog_ready  = w_run;
    // A loader write owns the cycle; the fetch retries next cycle.
    assign fetch_ready = w_run && !prog_valid;

    assign w_fetch_go = fetch_req && fetch_ready;
    assign w_prog_go  = prog_valid && prog_ready;

    assign w_wr_en   = busy || (w_prog_go && !w_p_oor);
    assign w_wr_idx  = busy ? r_cnt : prog_addr[IW-1:0];
    assign w_wr_data = busy ? '0 : prog_data;
`ifdef INSTR_PARITY_EN
    assign w_wr_word = {^w_wr_data, w_wr_data};
`else
    assign w_wr_word = w_wr_data;
`endif

    assign w_fword    = r_mem[w_fidx[IW-1:0]];
    assign w_bword    = r_mem[w_bidx[IW-1:0]];
    assign w_byte_sel = byte_addr[0] ? w_bword[HW-1:0] : w_bword[DATA_W-1:HW];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_cnt == IW'(DEPTH - 1)) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_RUN:   r_state <= S_RUN;
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    // Array has no reset of its own; the CLEAR sweep zeroes it after every reset.
    always_ff @(posedge CLK) begin
        if (w_wr_en)
            r_mem[w_wr_idx] <= w_wr_word;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fetch_valid <= 1'b0;
            r_instr       <= '0;
            r_byte        <= '0;
            r_addr_err    <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_go;
            if (w_fetch_go)
                r_instr <= w_f_oor ? '0 : w_fword[DATA_W-1:0];
            if (w_run && !w_b_oor)
                r_byte <= DATA_W'(w_byte_sel);
            else
                r_byte <= '0;
            if ((w_fetch_go && w_f_oor) || (w_prog_go && w_p_oor) || (w_run && w_b_oor))
                r_addr_err <= 1'b1;
        end
    end

`ifdef INSTR_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_parity_err <= 1'b0;
        else
            r_parity_err <= w_fetch_go && !w_f_oor && (^w_fword);
    end

    assign parity_err = r_parity_err;
`endif

    assign fetch_valid = r_fetch_valid;
    assign instruction = r_instr;
    assign byte_data   = r_byte;
    assign addr_err    = r_addr_err;

    assign op = r_instr[FIELD_W-1:0];
    assign rd = r_instr[2*FIELD_W-1:FIELD_W];
    assign rs = r_instr[3*FIELD_W-1:2*FIELD_W];
    assign rt = r_instr[4*FIELD_W-1:3*FIELD_W];

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: directed steps plus random traffic against an array model.
module tb_instr_mem_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;
    localparam int FW    = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          prog_valid = 1'b0;
    logic          prog_ready;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_data = '0;
    logic          fetch_req = 1'b0;
    logic          fetch_ready;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_valid;
    logic [DW-1:0] instruction;
    logic [FW-1:0] op, rd, rs, rt;
    logic [AW-1:0] byte_addr = '0;
    logic [DW-1:0] byte_data;
    logic          busy;
    logic          addr_err;
`ifdef INSTR_PARITY_EN
    logic          parity_err;
`endif

    instr_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .FIELD_W(FW)) dut (
        .CLK(CLK), .RST(RST),
        .prog_valid(prog_valid), .prog_ready(prog_ready),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .fetch_req(fetch_req), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .instruction(instruction),
        .op(op), .rd(rd), .rs(rs), .rt(rt),
        .byte_addr(byte_addr), .byte_data(byte_data),
        .busy(busy),
`ifdef INSTR_PARITY_EN
        .parity_err(parity_err),
`endif
        .addr_err(addr_err)
    );

    always #5 CLK = ~CLK;

    int            n_chk = 0;
    int            n_err = 0;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] e_instr = '0;
    logic [DW-1:0] e_byte  = '0;
    logic          e_fv    = 1'b0;
    logic          e_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        e_instr = '0;
        e_byte  = '0;
        e_fv    = 1'b0;
        e_err   = 1'b0;
    endtask

    task automatic drive(input logic pv, input int pa, input int pd,
                         input logic fr, input int fa, input int ba);
        prog_valid = pv;
        prog_addr  = AW'(pa);
        prog_data  = DW'(pd);
        fetch_req  = fr;
        fetch_addr = AW'(fa);
        byte_addr  = AW'(ba);
    endtask

    // One RUN cycle: predict from the model, clock, compare.
    task automatic step();
        int fi, bi;
        #1;
        chk("prog_ready", 32'(prog_ready), 32'd1);
        chk("fetch_ready", 32'(fetch_ready), 32'(!prog_valid));
        if (prog_valid && int'(prog_addr) >= DEPTH) e_err = 1'b1;
        e_fv = fetch_req && !prog_valid;
        if (e_fv) begin
            fi = int'(fetch_addr) / 2;
            if (fi >= DEPTH) begin
                e_instr = '0;
                e_err   = 1'b1;
            end else begin
                e_instr = m_mem[fi];
            end
        end
        bi = int'(byte_addr) / 2;
        if (bi >= DEPTH) begin
            e_byte = '0;
            e_err  = 1'b1;
        end else if (byte_addr[0]) begin
            e_byte = m_mem[bi] % 256;
        end else begin
            e_byte = m_mem[bi] / 256;
        end
        if (prog_valid && int'(prog_addr) < DEPTH) m_mem[prog_addr] = prog_data;
        @(posedge CLK);
        #1;
        chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
        chk("instruction", 32'(instruction), 32'(e_instr));
        chk("op", 32'(op), 32'(e_instr % 16));
        chk("rd", 32'(rd), 32'((e_instr / 16) % 16));
        chk("rs", 32'(rs), 32'((e_instr / 256) % 16));
        chk("rt", 32'(rt), 32'(e_instr / 4096));
        chk("byte_data", 32'(byte_data), 32'(e_byte));
        chk("addr_err", 32'(addr_err), 32'(e_err));
    endtask

    // Releases reset and counts cycles with busy high.
    task automatic clear_count(input string tag);
        int n;
        n = 0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        while (busy === 1'b1 && n < 400) begin
            n++;
            @(posedge CLK);
            #1;
        end
        chk(tag, 32'(n), 32'd256);
    endtask

    initial begin
        model_reset();
        drive(1'b0, 0, 0, 1'b1, 0, 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_instruction", 32'(instruction), 32'd0);
        chk("rst_byte_data", 32'(byte_data), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_prog_ready", 32'(prog_ready), 32'd0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        drive(1'b0, 0, 0, 1'b0, 0, 0);

        clear_count("T1_clear_len");
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, 0, 0, 1'b1, 2 * a, 2 * a + 1);
            step();
        end

        drive(1'b1, 3, 16'hA5C1, 1'b0, 0, 6);
        step();
        chk("T4_old_on_write", 32'(byte_data), 32'd0);
        drive(1'b0, 0, 0, 1'b1, 6, 6);
        step();
        chk("T2_fetch_valid", 32'(fetch_valid), 32'd1);
        chk("T2_instruction", 32'(instruction), 32'hA5C1);
        chk("T2_op", 32'(op), 32'h1);
        chk("T2_rd", 32'(rd), 32'hC);
        chk("T2_rs", 32'(rs), 32'h5);
        chk("T2_rt", 32'(rt), 32'hA);
        chk("T4_byte_hi", 32'(byte_data), 32'h00A5);
        drive(1'b0, 0, 0, 1'b0, 0, 7);
        step();
        chk("T4_byte_lo", 32'(byte_data), 32'h00C1);
        chk("hold_instruction", 32'(instruction), 32'hA5C1);
        chk("hold_fetch_valid", 32'(fetch_valid), 32'd0);

        drive(1'b1, 3, 16'h1234, 1'b1, 6, 0);
        #1;
        chk("T3_fetch_stall", 32'(fetch_ready), 32'd0);
        step();
        chk("T3_no_fetch", 32'(fetch_valid), 32'd0);
        drive(1'b0, 0, 0, 1'b1, 6, 0);
        step();
        chk("T3_new_data", 32'(instruction), 32'h1234);

        repeat (600) begin
            drive(($urandom_range(0, 3) == 0), int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2 * DEPTH - 1)), int'($urandom_range(0, 2 * DEPTH - 1)));
            step();
        end
        chk("in_range_no_err", 32'(addr_err), 32'd0);

        drive(1'b0, 0, 0, 1'b1, 16'h0200, 0);
        step();
        chk("T5_fetch_valid", 32'(fetch_valid), 32'd1);
        chk("T5_instruction", 32'(instruction), 32'd0);
        chk("T5_addr_err", 32'(addr_err), 32'd1);

        repeat (200) begin
            drive(($urandom_range(0, 3) == 0), int'($urandom_range(0, 16'hFFFF)),
                  int'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 16'hFFFF)));
            step();
        end
        chk("T5_sticky", 32'(addr_err), 32'd1);

        drive(1'b0, 0, 0, 1'b0, 0, 0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (100) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        model_reset();
        chk("T6_busy_in_rst", 32'(busy), 32'd1);
        chk("T6_addr_err_cleared", 32'(addr_err), 32'd0);
        chk("T6_instr_cleared", 32'(instruction), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        chk("T6_busy_held", 32'(busy), 32'd1);
        clear_count("T6_clear_len");
        drive(1'b0, 0, 0, 1'b1, 6, 6);
        step();
        chk("T6_word3_cleared", 32'(instruction), 32'd0);

`ifdef INSTR_PARITY_EN
        drive(1'b1, 5, 16'h0001, 1'b0, 0, 0);
        step();
        dut.r_mem[5][DW] = ~dut.r_mem[5][DW];
        drive(1'b0, 0, 0, 1'b1, 10, 0);
        step();
        chk("T6_parity_err", 32'(parity_err), 32'd1);
        chk("T6_parity_instr", 32'(instruction), 32'h0001);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
